vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between two users: the scan-out pixel fetch, driven by the VGA timing counters, and MCU-side reel/graphics writes.
- Scan-out has absolute priority.
- Writes are buffered in a small FIFO and drained only on cycles outside the visible region.
- Sits between the VGA timing generator, the SPI/MCU write path and the framebuffer RAM; feeds the colour output stage.

---
 rtl/vga_fb_arbiter_if.sv | 31 +++
 rtl/vga_fb_arbiter.sv | 144 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Write-request handshake and framebuffer RAM bus shared by vga_fb_arbiter and its neighbours.
// With FB_DOUBLE_BUFFER_EN the RAM address gains a bank MSB.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int MEM_AW = ADDR_W + 1;
`else
    localparam int MEM_AW = ADDR_W;
`endif

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: scan-out fetch owns the RAM during visible video, queued MCU
// writes drain in blanking. Optional front/back banking under FB_DOUBLE_BUFFER_EN.
module vga_fb_arbiter #(
    parameter int H_DISPLAY_START = 144,
    parameter int V_DISPLAY_START = 35,
    parameter int FB_W            = 160,
    parameter int FB_H            = 120,
    parameter int SCALE_SHIFT     = 2,
    parameter int ADDR_W          = 15,
    parameter int DATA_W          = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              active_video,
`ifdef FB_DOUBLE_BUFFER_EN
    input  logic              swap_req,
    output logic              front_bank,
`endif
    vga_fb_arbiter_if.slave   bus,
    output logic [DATA_W-1:0] pixel_rgb,
    output logic              pixel_active,
    output logic [2:0]        fifo_level
);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int MEM_AW = ADDR_W + 1;
`else
    localparam int MEM_AW = ADDR_W;
`endif
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int STAGES = 3;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_FETCH, SLOT_WRITE} slot_e;

    slot_e             slot;
    logic              push, pop;
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [10:0]       hoff;
    logic [9:0]        voff;
    logic [ADDR_W-1:0] col, row, fetch_addr;
    logic [MEM_AW-1:0] fetch_word, head_word;
    logic [STAGES:1]   vld_pipe;

    assign bus.wr_ready = (fifo_level != 3'(FIFO_DEPTH));
    assign push         = bus.wr_valid && bus.wr_ready;
    assign pop          = (slot == SLOT_WRITE);

    // Pops look only at the registered level, so a fresh entry waits one cycle.
    always_comb begin
        slot = SLOT_IDLE;
        if (active_video)          slot = SLOT_FETCH;
        else if (fifo_level != '0) slot = SLOT_WRITE;
    end

    assign hoff       = hcount - 11'(H_DISPLAY_START);
    assign voff       = vcount - 10'(V_DISPLAY_START);
    assign col        = ADDR_W'(hoff >> SCALE_SHIFT);
    assign row        = ADDR_W'(voff >> SCALE_SHIFT);
    assign fetch_addr = row * ADDR_W'(FB_W) + col;

`ifdef FB_DOUBLE_BUFFER_EN
    logic fifo_bank [FIFO_DEPTH];
    logic swap_pend;
    logic swap_now;

    assign swap_now   = swap_pend && (hcount == '0) && (vcount == '0);
    assign fetch_word = {front_bank, fetch_addr};
    assign head_word  = {fifo_bank[rd_ptr[PTR_W-1:0]], fifo_addr[rd_ptr[PTR_W-1:0]]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_bank <= 1'b0;
            swap_pend  <= 1'b0;
        end else if (swap_now) begin
            front_bank <= ~front_bank;
            swap_pend  <= 1'b0;
        end else if (swap_req) begin
            swap_pend  <= 1'b1;
        end
    end

    // Tag each entry with the bank that was back when it was accepted.
    always_ff @(posedge clk)
        if (push) fifo_bank[wr_ptr[PTR_W-1:0]] <= ~front_bank;
`else
    assign fetch_word = fetch_addr;
    assign head_word  = fifo_addr[rd_ptr[PTR_W-1:0]];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= bus.wr_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (slot)
                SLOT_FETCH: bus.mem_addr <= fetch_word;
                SLOT_WRITE: begin
                    bus.mem_addr  <= head_word;
                    bus.mem_wdata <= fifo_data[rd_ptr[PTR_W-1:0]];
                    bus.mem_we    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read data lands two cycles after the slot; blank the pixel when that slot was not visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            pixel_rgb <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], active_video};
            pixel_rgb <= vld_pipe[STAGES-1] ? bus.mem_rdata : '0;
        end
    end

    assign pixel_active = vld_pipe[STAGES];
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter (single-bank build): a bench RAM answers the DUT,
// expected writes and pixels are queued as stimulus is driven and retired as outputs appear.
module tb_vga_fb_arbiter;
    typedef struct {logic [14:0] addr; logic [7:0] data;} wr_t;
    typedef struct {int unsigned due; logic act; logic [7:0] val;} pix_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        active_video;
    logic [7:0]  pixel_rgb;
    logic        pixel_active;
    logic [2:0]  fifo_level;

    vga_fb_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus();

    vga_fb_arbiter dut (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .active_video(active_video), .bus(bus), .pixel_rgb(pixel_rgb),
        .pixel_active(pixel_active), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    logic [7:0] ram  [32768];
    logic [7:0] gold [32768];
    logic       loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 32768; a++) ram[a] <= 8'(a) ^ 8'hA5;
            loaded <= 1'b1;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int unsigned total = 0, bad = 0, cyc = 0;
    wr_t         mq[$];
    pix_t        pq[$];
    int          m_lvl = 0;
    logic [14:0] exp_addr = '0;
    logic        last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [14:0] fb_addr(input int h, input int v);
        return 15'(((v - 35) / 4) * 160 + (h - 144) / 4);
    endfunction

    task automatic drive(input logic av, input int h, input int v,
                         input logic wv, input logic [14:0] wa, input logic [7:0] wd);
        active_video = av; hcount = 11'(h); vcount = 10'(v);
        bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
    endtask

    task automatic tick();
        logic m_acc, m_pop, exp_we;
        logic [7:0] exp_wdata;
        wr_t  e;
        pix_t p;
        chk("wr_ready", 32'(bus.wr_ready), 32'(m_lvl != 4));
        m_acc = bus.wr_valid && (m_lvl != 4);
        m_pop = !active_video && (m_lvl != 0);
        exp_we = 1'b0; exp_wdata = '0;
        p.due = cyc + 3; p.act = active_video; p.val = '0;
        if (active_video) begin
            exp_addr = fb_addr(int'(hcount), int'(vcount));
            p.val = gold[exp_addr];
        end else if (m_pop) begin
            e = mq.pop_front();
            exp_we = 1'b1; exp_addr = e.addr; exp_wdata = e.data;
            gold[e.addr] = e.data;
        end
        pq.push_back(p);
        if (m_acc) begin
            e.addr = bus.wr_addr; e.data = bus.wr_data;
            mq.push_back(e);
        end
        m_lvl = m_lvl + int'(m_acc) - int'(m_pop);
        last_acc = m_acc;
        @(posedge clk); #1; cyc++;
        chk("fifo_level", 32'(fifo_level), 32'(m_lvl));
        chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        if (exp_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            chk("pixel_active", 32'(pixel_active), 32'(p.act));
            chk("pixel_rgb", 32'(pixel_rgb), 32'(p.val));
        end
    endtask

    task automatic check_reset_state();
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);
        chk("rst_pixel_rgb", 32'(pixel_rgb), 0);
        chk("rst_pixel_active", 32'(pixel_active), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_reset_state();
        mq.delete(); pq.delete(); m_lvl = 0; exp_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_state();
        reset_n = 1'b1;
    endtask

    task automatic push_wait(input logic av, input int h, input int v,
                             input logic [14:0] wa, input logic [7:0] wd);
        int n = 0;
        do begin
            drive(av, h, v, 1'b1, wa, wd);
            tick();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("push_timeout", 0, 1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin drive(1'b0, 10, 10, 1'b0, '0, '0); tick(); end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) gold[a] = 8'(a) ^ 8'hA5;
        reset_n = 1'b0;
        drive(1'b0, 0, 0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset_n = 1'b1;

        // First visible cell and last visible cell
        drive(1'b1, 144, 35, 1'b0, '0, '0); tick();
        chk("addr_first", 32'(bus.mem_addr), 0);
        drive(1'b1, 783, 514, 1'b0, '0, '0); tick();
        chk("addr_last", 32'(bus.mem_addr), 19199);
        blank(3);

        // Fill during active video, stall a fifth write, drain in blanking
        for (int i = 0; i < 4; i++) push_wait(1'b1, 200 + i * 4, 100, 15'(10 + i), 8'(8'h30 + i));
        chk("full_ready", 32'(bus.wr_ready), 0);
        for (int i = 0; i < 2; i++) begin drive(1'b1, 300, 200, 1'b1, 15'd10, 8'h99); tick(); end
        push_wait(1'b0, 10, 10, 15'd10, 8'h99);
        blank(6);
        drive(1'b1, 184, 35, 1'b0, '0, '0); tick();
        blank(3);

        // Push/pop together at level 2, then push into an empty FIFO
        push_wait(1'b1, 150, 40, 15'd20, 8'h11);
        push_wait(1'b1, 154, 40, 15'd21, 8'h12);
        push_wait(1'b0, 10, 10, 15'd22, 8'h13);
        chk("pushpop_level", 32'(fifo_level), 2);
        blank(4);
        push_wait(1'b0, 10, 10, 15'd23, 8'h14);
        blank(3);

        // Active video returns with the FIFO still holding entries
        push_wait(1'b1, 160, 50, 15'd30, 8'h21);
        push_wait(1'b1, 164, 50, 15'd31, 8'h22);
        blank(1);
        drive(1'b1, 168, 50, 1'b0, '0, '0); tick();
        drive(1'b1, 172, 50, 1'b0, '0, '0); tick();
        blank(4);

        // Reset mid-frame with three writes queued
        for (int i = 0; i < 3; i++) push_wait(1'b1, 400, 300, 15'(40 + i), 8'(8'h50 + i));
        drive(1'b1, 404, 300, 1'b0, '0, '0); tick();
        do_reset();
        blank(6);

        // Random mix with overlapping addresses so fetches see earlier writes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0)
                drive(1'b1, 144 + $urandom_range(0, 31), 35 + $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 15'($urandom_range(0, 7)), 8'($urandom));
            else
                drive(1'b0, 5, 5, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 7)), 8'($urandom));
            tick();
        end
        blank(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
